// File: rtl/ascii_history_display.sv
// ascii_history_display: shift-register history of the last NUM_CHARS key codes,
// each shown as two hex digits on 7-segment displays, plus a keypress counter.
module ascii_history_display #(
   parameter int unsigned NUM_CHARS        = 2,
   parameter bit          BLANK_ON_RELEASE = 1'b1,
   parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               ascii_in,
   input  logic                     ascii_valid,
   input  logic                     key_release,
   input  logic                     capital,
   input  logic                     clear,
   output logic [14*NUM_CHARS-1:0]  hex_chars,
   output logic [13:0]              hex_count,
   output logic [7:0]               press_count
);

   typedef enum logic [1:0] {StIdle, StShow, StReleased} state_e;

   localparam logic [6:0] SegBlank = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
   localparam logic [6:0] SegZero  = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

   // Hex nibble to segments (g..a), polarity applied.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return SEG_ACTIVE_LOW ? s : ~s;
   endfunction

   state_e                          state_q, state_d;
   logic [NUM_CHARS-1:0][7:0]       hist_q, hist_d;
   logic [NUM_CHARS-1:0]            vld_q, vld_d;
   logic [7:0]                      cnt_q, cnt_d;
   logic [14*NUM_CHARS-1:0]         hex_chars_q, hex_chars_d;
   logic [13:0]                     hex_count_q, hex_count_d;

   logic       accept;
   logic [7:0] code;

   assign accept = ascii_valid && (ascii_in != 8'h00) && !clear;

   // Caps conversion of lowercase letters at acceptance time.
   always_comb begin
      code = ascii_in;
      if (capital && (ascii_in >= 8'd97) && (ascii_in <= 8'd122)) begin
         code = ascii_in - 8'd32;
      end
   end

   // History shift, counter and slot-0 blanking FSM; clear dominates accept, accept
   // dominates release.
   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = StIdle;
         hist_d  = '0;
         vld_d   = '0;
         cnt_d   = 8'h00;
      end else if (accept) begin
         for (int i = int'(NUM_CHARS) - 1; i >= 1; i--) begin
            hist_d[i] = hist_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
         hist_d[0] = code;
         vld_d[0]  = 1'b1;
         cnt_d     = cnt_q + 8'd1;
         state_d   = StShow;
      end else if (key_release && BLANK_ON_RELEASE && (state_q == StShow)) begin
         state_d = StReleased;
      end
   end

   // Display encoding from the current state; registered, so it lags by one edge.
   always_comb begin
      hex_chars_d = '0;
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
         if ((i == 0) ? (state_q != StShow) : !vld_q[i]) begin
            hex_chars_d[14*i +: 14] = {SegBlank, SegBlank};
         end else begin
            hex_chars_d[14*i +: 14] = {seg7(hist_q[i][7:4]), seg7(hist_q[i][3:0])};
         end
      end
      hex_count_d = {seg7(cnt_q[7:4]), seg7(cnt_q[3:0])};
   end

   // State and display registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         hist_q      <= '0;
         vld_q       <= '0;
         cnt_q       <= 8'h00;
         hex_chars_q <= {NUM_CHARS{{SegBlank, SegBlank}}};
         hex_count_q <= {SegZero, SegZero};
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         vld_q       <= vld_d;
         cnt_q       <= cnt_d;
         hex_chars_q <= hex_chars_d;
         hex_count_q <= hex_count_d;
      end
   end

   assign hex_chars   = hex_chars_q;
   assign hex_count   = hex_count_q;
   assign press_count = cnt_q;

endmodule

// File: tb/tb_ascii_history_display.sv
// Self-checking bench for ascii_history_display: directed table, wrap and reset
// sequences, then random stimulus against a behavioural model.
module tb_ascii_history_display;

   localparam int N = 2;

   localparam logic [6:0] SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   localparam logic [6:0] BLANK = 7'b1111111;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      ascii_in;
   logic            ascii_valid, key_release, capital, clear;
   logic [14*N-1:0] hex_chars;
   logic [13:0]     hex_count;
   logic [7:0]      press_count;

   always #5 clk = ~clk;

   ascii_history_display #(
      .NUM_CHARS(N),
      .BLANK_ON_RELEASE(1'b1),
      .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ascii_in(ascii_in),
      .ascii_valid(ascii_valid),
      .key_release(key_release),
      .capital(capital),
      .clear(clear),
      .hex_chars(hex_chars),
      .hex_count(hex_count),
      .press_count(press_count)
   );

   // Behavioural model: newest-first list of accepted codes, number of presses
   // since clear, and whether the newest key is currently being shown.
   logic [7:0] m_hist [N];
   int         m_nvalid;
   bit         m_show;
   logic [7:0] m_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit         v, rel, cap, clr;
      logic [7:0] a;
      logic [7:0] e0;
      bit         b0;
      logic [7:0] e1;
      bit         b1;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl [17];

   function automatic logic [13:0] enc_byte(input logic [7:0] b, input bit blank);
      if (blank) return {BLANK, BLANK};
      return {SEG[b[7:4]], SEG[b[3:0]]};
   endfunction

   function automatic logic [14*N-1:0] model_disp();
      logic [14*N-1:0] r;
      for (int i = 0; i < N; i++) begin
         r[14*i +: 14] = enc_byte(m_hist[i], (i == 0) ? !m_show : (i >= m_nvalid));
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_hist[i] = 8'h00;
      m_nvalid = 0;
      m_show   = 1'b0;
      m_cnt    = 8'h00;
   endtask

   task automatic model_apply(input bit v, input bit rel, input bit cap, input bit clr,
                              input logic [7:0] a);
      logic [7:0] c;
      if (clr) begin
         model_reset();
      end else if (v && a != 8'h00) begin
         c = (cap && a >= 8'd97 && a <= 8'd122) ? a - 8'd32 : a;
         for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = c;
         if (m_nvalid < N) m_nvalid++;
         m_show = 1'b1;
         m_cnt  = m_cnt + 8'd1;
      end else if (rel && m_show) begin
         m_show = 1'b0;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus; display outputs are compared against the model
   // state from before the edge, press_count against the state after it.
   task automatic step(input bit v, input bit rel, input bit cap, input bit clr,
                       input logic [7:0] a);
      logic [14*N-1:0] exp_chars;
      logic [13:0]     exp_cnt;
      ascii_valid = v;
      key_release = rel;
      capital     = cap;
      clear       = clr;
      ascii_in    = a;
      exp_chars   = model_disp();
      exp_cnt     = enc_byte(m_cnt, 1'b0);
      @(posedge clk);
      #1;
      model_apply(v, rel, cap, clr, a);
      ascii_valid = 1'b0;
      key_release = 1'b0;
      clear       = 1'b0;
      check("press_count", {56'd0, press_count}, {56'd0, m_cnt});
      check("hex_chars", {36'd0, hex_chars}, {36'd0, exp_chars});
      check("hex_count", {50'd0, hex_count}, {50'd0, exp_cnt});
   endtask

   initial begin
      rst = 1'b1;
      ascii_in = 8'h00; ascii_valid = 1'b0; key_release = 1'b0;
      capital = 1'b0; clear = 1'b0;
      model_reset();

      tbl[0]  = '{1, 0, 0, 0, 8'h61, 8'h61, 0, 8'h00, 1, 8'd1};
      tbl[1]  = '{1, 0, 1, 0, 8'h7A, 8'h5A, 0, 8'h61, 0, 8'd2};
      tbl[2]  = '{0, 0, 0, 0, 8'h00, 8'h5A, 0, 8'h61, 0, 8'd2};
      tbl[3]  = '{1, 0, 1, 0, 8'h31, 8'h31, 0, 8'h5A, 0, 8'd3};
      tbl[4]  = '{0, 0, 0, 1, 8'h00, 8'h00, 1, 8'h00, 1, 8'd0};
      tbl[5]  = '{1, 0, 0, 0, 8'h41, 8'h41, 0, 8'h00, 1, 8'd1};
      tbl[6]  = '{1, 0, 0, 0, 8'h42, 8'h42, 0, 8'h41, 0, 8'd2};
      tbl[7]  = '{1, 0, 0, 0, 8'h43, 8'h43, 0, 8'h42, 0, 8'd3};
      tbl[8]  = '{0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h42, 0, 8'd3};
      tbl[9]  = '{0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h42, 0, 8'd3};
      tbl[10] = '{1, 1, 0, 0, 8'h44, 8'h44, 0, 8'h43, 0, 8'd4};
      tbl[11] = '{1, 0, 0, 0, 8'h00, 8'h44, 0, 8'h43, 0, 8'd4};
      tbl[12] = '{1, 0, 0, 1, 8'h45, 8'h00, 1, 8'h00, 1, 8'd0};
      tbl[13] = '{0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 8'd0};
      tbl[14] = '{1, 0, 1, 0, 8'h61, 8'h41, 0, 8'h00, 1, 8'd1};
      tbl[15] = '{1, 0, 1, 0, 8'h7B, 8'h7B, 0, 8'h41, 0, 8'd2};
      tbl[16] = '{1, 0, 1, 0, 8'h60, 8'h60, 0, 8'h7B, 0, 8'd3};

      #12;
      check("reset_chars", {36'd0, hex_chars}, {36'd0, {N{BLANK, BLANK}}});
      check("reset_count", {50'd0, hex_count}, {50'd0, SEG[0], SEG[0]});
      check("reset_press", {56'd0, press_count}, 64'd0);
      rst = 1'b0;

      // Directed table: apply the vector, one idle cycle, then compare the display.
      for (int k = 0; k < 17; k++) begin
         step(tbl[k].v, tbl[k].rel, tbl[k].cap, tbl[k].clr, tbl[k].a);
         step(0, 0, 0, 0, 8'h00);
         check($sformatf("tbl%0d_chars", k), {36'd0, hex_chars},
               {36'd0, enc_byte(tbl[k].e1, tbl[k].b1), enc_byte(tbl[k].e0, tbl[k].b0)});
         check($sformatf("tbl%0d_press", k), {56'd0, press_count}, {56'd0, tbl[k].cnt});
      end

      // Counter wrap after 256 accepted presses.
      step(0, 0, 0, 1, 8'h00);
      for (int k = 0; k < 255; k++) begin
         step(1, 0, 1'($urandom_range(0, 1)), 0, 8'($urandom_range(1, 255)));
      end
      check("wrap_ff", {56'd0, press_count}, 64'hFF);
      step(1, 0, 0, 0, 8'h37);
      check("wrap_00", {56'd0, press_count}, 64'h00);
      step(0, 0, 0, 0, 8'h00);
      check("wrap_hex", {50'd0, hex_count}, {50'd0, SEG[0], SEG[0]});

      // Randomised stimulus against the model.
      for (int k = 0; k < 600; k++) begin
         step(($urandom % 3) == 0, ($urandom % 4) == 0, 1'($urandom % 2),
              ($urandom % 40) == 0,
              (($urandom % 8) == 0) ? 8'h00 : 8'($urandom_range(8'h30, 8'h7F)));
      end

      // Asynchronous reset between edges while a key is shown.
      step(1, 0, 0, 0, 8'h55);
      step(0, 0, 0, 0, 8'h00);
      #3;
      rst = 1'b1;
      #1;
      check("arst_chars", {36'd0, hex_chars}, {36'd0, {N{BLANK, BLANK}}});
      check("arst_count", {50'd0, hex_count}, {50'd0, SEG[0], SEG[0]});
      check("arst_press", {56'd0, press_count}, 64'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1, 0, 1, 0, 8'h62);
      step(0, 0, 0, 0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
